// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types for the guarded functional/ijtag data mux: per-channel FSM state
// and the guard-counter width helper.
package firebird7_in_gate1_tessent_data_mux_pkg;

    typedef enum logic [1:0] {
        ST_FUNC          = 2'd0,
        ST_HOLD_TO_IJTAG = 2'd1,
        ST_IJTAG         = 2'd2,
        ST_HOLD_TO_FUNC  = 2'd3
    } mux_state_e;

    // Counter counts GUARD_CYCLES-1 down to 0; keep at least one bit so GUARD_CYCLES=0 still elaborates.
    function automatic int guard_cnt_w(input int guard_cycles);
        int w;
        w = $clog2(guard_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_guarded_chan.sv
// One channel of the guarded mux: handover FSM, guard counter, output register and,
// with TESSENT_DATA_MUX_SELECT_SYNC_EN defined, a 2-flop select synchronizer.
module firebird7_in_gate1_tessent_data_mux_guarded_chan
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH        = 3,
    parameter int GUARD_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic [WIDTH-1:0] func_i,
    input  logic [WIDTH-1:0] ijtag_i,
    output logic [WIDTH-1:0] data_o,
    output logic             active_o
);

    localparam int            CW        = guard_cnt_w(GUARD_CYCLES);
    localparam bit            HAS_GUARD = (GUARD_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LOAD  = HAS_GUARD ? CW'(GUARD_CYCLES - 1) : '0;

    logic sel_eff;

`ifdef TESSENT_DATA_MUX_SELECT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sel_i};
        end
    end

    assign sel_eff = sync_q[1];
`else
    assign sel_eff = sel_i;
`endif

    mux_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] data_q;
    logic            active_q;

    // active_q is registered alongside data_q so it flags exactly the cycles whose data came from ijtag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_FUNC;
            cnt_q    <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
        end else begin
            active_q <= (state_q == ST_IJTAG);
            case (state_q)
                ST_FUNC: begin
                    data_q <= func_i;
                    if (sel_eff) begin
                        if (HAS_GUARD) begin
                            state_q <= ST_HOLD_TO_IJTAG;
                            cnt_q   <= CNT_LOAD;
                        end else begin
                            state_q <= ST_IJTAG;
                        end
                    end
                end
                // Abort is checked before counter expiry so a dropped select always wins.
                ST_HOLD_TO_IJTAG: begin
                    if (!sel_eff) begin
                        state_q <= ST_FUNC;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_IJTAG;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_IJTAG: begin
                    data_q <= ijtag_i;
                    if (!sel_eff) begin
                        if (HAS_GUARD) begin
                            state_q <= ST_HOLD_TO_FUNC;
                            cnt_q   <= CNT_LOAD;
                        end else begin
                            state_q <= ST_FUNC;
                        end
                    end
                end
                ST_HOLD_TO_FUNC: begin
                    if (sel_eff) begin
                        state_q <= ST_IJTAG;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_FUNC;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FUNC;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_o   = data_q;
    assign active_o = active_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_guarded.sv
// Guarded functional/ijtag data mux, CHANNELS independent channels of WIDTH bits.
// Define TESSENT_DATA_MUX_SELECT_SYNC_EN to add a 2-flop synchronizer on each select.
module firebird7_in_gate1_tessent_data_mux_guarded
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH        = 3,
    parameter int CHANNELS     = 1,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                      ijtag_tck,
    input  logic                      ijtag_reset,
    input  logic [CHANNELS-1:0]       ijtag_select,
    input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
    input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       ijtag_active
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        firebird7_in_gate1_tessent_data_mux_guarded_chan #(
            .WIDTH        (WIDTH),
            .GUARD_CYCLES (GUARD_CYCLES)
        ) u_chan (
            .clk_i    (ijtag_tck),
            .rst_i    (ijtag_reset),
            .sel_i    (ijtag_select[c]),
            .func_i   (functional_data_in[c*WIDTH +: WIDTH]),
            .ijtag_i  (ijtag_data_in[c*WIDTH +: WIDTH]),
            .data_o   (data_out[c*WIDTH +: WIDTH]),
            .active_o (ijtag_active[c])
        );
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_guarded.sv
// Directed bench for the guarded data mux: three DUT configurations, expected values
// queued as stimulus is driven and compared one cycle later.
module tb_firebird7_in_gate1_tessent_data_mux_guarded;

`ifdef TESSENT_DATA_MUX_SELECT_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel0, a0;
    logic [2:0]  f0, j0, d0;
    logic        sel1, a1;
    logic [2:0]  f1, j1, d1;
    logic [3:0]  sel2, a2;
    logic [31:0] f2, j2, d2;

    firebird7_in_gate1_tessent_data_mux_guarded #(.WIDTH(3), .CHANNELS(1), .GUARD_CYCLES(2)) u_g2 (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_select(sel0),
        .functional_data_in(f0), .ijtag_data_in(j0), .data_out(d0), .ijtag_active(a0));

    firebird7_in_gate1_tessent_data_mux_guarded #(.WIDTH(3), .CHANNELS(1), .GUARD_CYCLES(0)) u_g0 (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_select(sel1),
        .functional_data_in(f1), .ijtag_data_in(j1), .data_out(d1), .ijtag_active(a1));

    firebird7_in_gate1_tessent_data_mux_guarded #(.WIDTH(8), .CHANNELS(4), .GUARD_CYCLES(2)) u_c4 (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_select(sel2),
        .functional_data_in(f2), .ijtag_data_in(j2), .data_out(d2), .ijtag_active(a2));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] d;
        logic [3:0]  a;
    } exp_t;

    exp_t sb[$];

    task automatic push(input int dut, input string tag, input logic [31:0] d, input logic [3:0] a);
        exp_t e;
        e.dut = dut; e.tag = tag; e.d = d; e.a = a;
        sb.push_back(e);
    endtask

    task automatic push3(input int dut, input string tag, input logic [2:0] d, input logic a);
        push(dut, tag, 32'(d), 4'(a));
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and drain everything queued for it.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0: begin cmp({e.tag, "/data0"}, 32'(d0), e.d); cmp({e.tag, "/act0"}, 32'(a0), 32'(e.a)); end
                1: begin cmp({e.tag, "/data1"}, 32'(d1), e.d); cmp({e.tag, "/act1"}, 32'(a1), 32'(e.a)); end
                default: begin cmp({e.tag, "/data2"}, d2, e.d); cmp({e.tag, "/act2"}, 32'(a2), 32'(e.a)); end
            endcase
        end
    endtask

    function automatic logic [7:0] fb(input int c, input int n);
        return 8'(16 * c + n);
    endfunction

    function automatic logic [7:0] jb(input int c, input int n);
        return 8'(160 + 16 * c + n);
    endfunction

    function automatic logic [31:0] pack_f(input int n);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = fb(c, n);
        return v;
    endfunction

    function automatic logic [31:0] pack_j(input int n);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = jb(c, n);
        return v;
    endfunction

    // Channels 0/2 selected: func until select reaches the FSM, 2 frozen cycles, then ijtag.
    function automatic logic [31:0] exp_c4(input int n);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) begin
            if (c % 2 == 1 || n <= SL) v[c*8 +: 8] = fb(c, n);
            else if (n <= SL + 2)      v[c*8 +: 8] = fb(c, SL);
            else                       v[c*8 +: 8] = jb(c, n);
        end
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        sel0 = 1'b0; f0 = 3'b110; j0 = 3'b011;
        sel1 = 1'b0; f1 = 3'b111; j1 = 3'b001;
        sel2 = 4'b0000; f2 = 32'hA5A5_A5A5; j2 = 32'h5A5A_5A5A;

        // Reset with nonzero data inputs
        for (int i = 0; i < 3; i++) begin
            push3(0, "reset", 3'b000, 1'b0);
            push3(1, "reset", 3'b000, 1'b0);
            push(2, "reset", 32'h0, 4'h0);
            tick();
        end
        rst = 1'b0;
        f0 = 3'b101; j0 = 3'b010; f1 = 3'b011; f2 = pack_f(0); j2 = pack_j(0);
        push3(0, "release", 3'b101, 1'b0);
        push3(1, "release", 3'b011, 1'b0);
        push(2, "release", pack_f(0), 4'h0);
        tick();

        // Full handover func -> ijtag -> func with guard 2
        sel0 = 1'b1;
        for (int n = 0; n <= SL; n++) begin push3(0, "to_ij_func", 3'b101, 1'b0); tick(); end
        f0 = 3'b111;
        for (int n = 0; n < 2; n++) begin push3(0, "to_ij_hold", 3'b101, 1'b0); tick(); end
        push3(0, "ijtag", 3'b010, 1'b1); tick();
        j0 = 3'b110;
        push3(0, "ijtag_trk", 3'b110, 1'b1); tick();
        j0 = 3'b010; sel0 = 1'b0;
        for (int n = 0; n <= SL; n++) begin push3(0, "to_fn_ij", 3'b010, 1'b1); tick(); end
        j0 = 3'b111; f0 = 3'b001;
        for (int n = 0; n < 2; n++) begin push3(0, "to_fn_hold", 3'b010, 1'b0); tick(); end
        f0 = 3'b101;
        push3(0, "func_back", 3'b101, 1'b0); tick();
        f0 = 3'b011;
        push3(0, "func_trk", 3'b011, 1'b0); tick();

        // Select drops exactly as the guard counter expires: abort must win
        j0 = 3'b001;
        for (int n = 0; n <= SL + 3; n++) begin
            sel0 = (n < 2);
            f0 = 3'(n + 2);
            if (n == SL + 1 || n == SL + 2) push3(0, "abort_prio", 3'(SL + 2), 1'b0);
            else                            push3(0, "abort_prio", 3'(n + 2), 1'b0);
            tick();
        end

        // One-cycle select pulse never reaches ijtag
        for (int n = 0; n <= SL + 3; n++) begin
            sel0 = (n == 0);
            f0 = 3'(n + 2);
            if (n == SL + 1) push3(0, "pulse", 3'(SL + 2), 1'b0);
            else             push3(0, "pulse", 3'(n + 2), 1'b0);
            tick();
        end

        // Reset while frozen in the func->ijtag guard window
        sel0 = 1'b1; f0 = 3'b110;
        for (int n = 0; n <= SL; n++) begin push3(0, "pre_rst", 3'b110, 1'b0); tick(); end
        f0 = 3'b011;
        push3(0, "pre_rst_hold", 3'b110, 1'b0); tick();
        rst = 1'b1;
        push3(0, "mid_hold_rst", 3'b000, 1'b0); tick();
        rst = 1'b0; sel0 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            f0 = 3'(n + 3);
            push3(0, "post_rst", 3'(n + 3), 1'b0);
            tick();
        end

        // Zero guard: select toggles every cycle
        for (int n = 0; n < 8; n++) begin
            sel1 = (n % 2 == 0);
            f1 = 3'(n);
            j1 = 3'(7 - n);
            if (n % 2 == 1 && n >= 1 + SL) push3(1, "g0_toggle", 3'(7 - n), 1'b1);
            else                           push3(1, "g0_toggle", 3'(n), 1'b0);
            tick();
        end

        // Four channels, 0 and 2 selected together
        sel2 = 4'b0101;
        for (int n = 0; n <= SL + 4; n++) begin
            f2 = pack_f(n);
            j2 = pack_j(n);
            push(2, "multi_chan", exp_c4(n), (n >= SL + 3) ? 4'b0101 : 4'b0000);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_guarded.md
FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_GUARDED -- requirements
Module: firebird7_in_gate1_tessent_data_mux_guarded

Interface
REQ-001 Parameter WIDTH, default 3: bit width of each channel's data.
REQ-002 Parameter CHANNELS, default 1: number of independent mux channels.
REQ-003 Parameter GUARD_CYCLES, default 2: hold cycles on each select handover; 0 is legal.
REQ-004 ijtag_tck  input  1: sole clock; all state updates on its rising edge.
REQ-005 ijtag_reset  input  1: reset, synchronous and active-high.
REQ-006 ijtag_select  input  CHANNELS: per-channel request for ijtag data.
REQ-007 functional_data_in  input  CHANNELS*WIDTH: functional data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 ijtag_data_in  input  CHANNELS*WIDTH: ijtag data, same packing.
REQ-009 data_out  output  CHANNELS*WIDTH: registered muxed data, same packing.
REQ-010 ijtag_active  output  CHANNELS: per-channel flag, 1 only while that channel drives ijtag data.

Function
REQ-011 Each channel shall run an independent FSM: FUNC, HOLD_TO_IJTAG, IJTAG, HOLD_TO_FUNC.
REQ-012 FUNC: data_out channel <= functional_data_in channel every cycle (1-cycle latency).
REQ-013 IJTAG: data_out channel <= ijtag_data_in channel every cycle (1-cycle latency); ijtag_active=1.
REQ-014 HOLD states: data_out channel shall hold its last registered value; ijtag_active=0.
REQ-015 FUNC with select=1: GUARD_CYCLES>0 -> HOLD_TO_IJTAG, guard counter loaded GUARD_CYCLES-1; GUARD_CYCLES=0 -> IJTAG directly.
REQ-016 HOLD_TO_IJTAG: counter decrements each cycle; on counter=0 with select=1 -> IJTAG; output therefore frozen exactly GUARD_CYCLES cycles.
REQ-017 HOLD_TO_IJTAG with select=0 (abort): -> FUNC next cycle, no ijtag data ever driven.
REQ-018 IJTAG with select=0: mirror of REQ-015/016 via HOLD_TO_FUNC, ending in FUNC.
REQ-019 HOLD_TO_FUNC with select=1 (abort): -> IJTAG next cycle.
REQ-020 Abort shall take priority over counter expiry in the same cycle.
REQ-021 Guard counter width shall be max(1,$clog2(GUARD_CYCLES+1)); no wrap, it stops at 0.
REQ-022 Channels shall not interact; simultaneous transitions on any subset are legal.

Reset
REQ-023 With ijtag_reset=1 at a rising edge: all FSMs -> FUNC, counters -> 0, data_out -> 0, ijtag_active -> 0.
REQ-024 Reset mid-handover shall abort it; first post-reset cycle samples functional_data_in (or select per REQ-015).
REQ-025 Reset shall also clear synchronizer flops when REQ-026 is compiled in.

Configuration
REQ-026 Macro TESSENT_DATA_MUX_SELECT_SYNC_EN defined: ijtag_select passes through a 2-flop per-channel synchronizer (reset 0) before the FSM, adding 2 cycles select-to-state latency; data latency unchanged.
REQ-027 Macro undefined: ijtag_select feeds the FSM directly; no synchronizer flops exist.

Structure
REQ-028 Shared package firebird7_in_gate1_tessent_data_mux_pkg shall hold the FSM state enum (2-bit) and the guard-counter width function.
REQ-029 Sub-module firebird7_in_gate1_tessent_data_mux_guarded_chan shall implement one channel (FSM, counter, WIDTH register, optional sync); top instantiates CHANNELS copies via generate.

Verification
REQ-030 Reset: hold reset 3 cycles with inputs nonzero -> data_out=0, ijtag_active=0; release -> cycle after shows functional_data_in.
REQ-031 WIDTH=3, GUARD=2: func=3'b101, ijtag=3'b010, select 0->1 -> data_out stays 101 for 2 cycles, then 010, ijtag_active rises with it; select 1->0 -> 010 held 2 cycles, then 101.
REQ-032 GUARD=2: select pulses high 1 cycle -> data_out never shows ijtag value, ijtag_active never 1, back in FUNC.
REQ-033 GUARD=0: select toggles each cycle -> data_out alternates sources with 1-cycle latency, no hold cycles.
REQ-034 CHANNELS=4, WIDTH=8: select=4'b0101 simultaneously -> channels 0,2 switch after guard, channels 1,3 track functional data every cycle.
REQ-035 With TESSENT_DATA_MUX_SELECT_SYNC_EN: select 0->1 -> first hold cycle begins 2 cycles later than REQ-031; reset mid-HOLD_TO_IJTAG -> REQ-023 values.
